// File: rtl/controller_if.sv
// Controller <-> datapath control bundle: latched instruction in, selects/enables/pulses out.
// With CONTROLLER_MEMORY_WAIT_EN defined the bundle also carries memory_ready.
interface controller_if #(
  parameter int COUNT_WIDTH = 16
);
  logic [15:0]            instruction;
  logic [1:0]             alu_a_select;
  logic                   alu_b_select;
  logic [2:0]             alu_operation;
  logic                   program_counter_write_enable;
  logic                   instruction_write_enable;
  logic                   status_write_enable;
  logic                   register_write_enable;
  logic                   instruction_done;
  logic                   illegal_instruction;
  logic [COUNT_WIDTH-1:0] retired_count;
`ifdef CONTROLLER_MEMORY_WAIT_EN
  logic                   memory_ready;

  modport master (
    input  instruction, memory_ready,
    output alu_a_select, alu_b_select, alu_operation,
           program_counter_write_enable, instruction_write_enable,
           status_write_enable, register_write_enable,
           instruction_done, illegal_instruction, retired_count
  );
  modport slave (
    output instruction, memory_ready,
    input  alu_a_select, alu_b_select, alu_operation,
           program_counter_write_enable, instruction_write_enable,
           status_write_enable, register_write_enable,
           instruction_done, illegal_instruction, retired_count
  );
`else
  modport master (
    input  instruction,
    output alu_a_select, alu_b_select, alu_operation,
           program_counter_write_enable, instruction_write_enable,
           status_write_enable, register_write_enable,
           instruction_done, illegal_instruction, retired_count
  );
  modport slave (
    output instruction,
    input  alu_a_select, alu_b_select, alu_operation,
           program_counter_write_enable, instruction_write_enable,
           status_write_enable, register_write_enable,
           instruction_done, illegal_instruction, retired_count
  );
`endif
endinterface

// File: rtl/controller.sv
// Multicycle control FSM (FETCH/LOAD/DECODE/EXECUTE/WRITEBACK) for the 16-bit CPU; Moore outputs.
// Optional CONTROLLER_MEMORY_WAIT_EN: FETCH also waits for memory_ready.
module controller #(
  parameter int MEMORY_LATENCY = 1,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic         clock,
  input  logic         reset,
  controller_if.master bus
);
  localparam int LAT = (MEMORY_LATENCY < 1) ? 1 : MEMORY_LATENCY;
  localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] LAT_LAST = CW'(LAT - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_CMP = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;

  typedef enum logic [2:0] {
    S_FETCH, S_LOAD, S_DECODE, S_EXECUTE, S_WRITEBACK
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;

  logic       mem_ok;
  logic       lat_done;
  logic [3:0] code;
  logic       dec_legal;
  logic       dec_arith;
  logic       dec_cmp;
  logic [1:0] dec_a;
  logic [2:0] dec_op;
  logic       unused_fields;

`ifdef CONTROLLER_MEMORY_WAIT_EN
  assign mem_ok = bus.memory_ready;
`else
  assign mem_ok = 1'b1;
`endif

  assign lat_done      = (cnt_q == LAT_LAST);
  assign unused_fields = ^{bus.instruction[11:8], bus.instruction[3:0]};

  // Register form carries its ALU code in ext; immediate form carries the same code in op.
  always_comb begin
    code      = (bus.instruction[15:12] == 4'b0000) ? bus.instruction[7:4]
                                                    : bus.instruction[15:12];
    dec_legal = 1'b1;
    dec_arith = 1'b0;
    dec_cmp   = 1'b0;
    dec_op    = OP_ADD;
    case (code)
      4'b0101: begin dec_op = OP_ADD; dec_arith = 1'b1; end
      4'b1001: begin dec_op = OP_SUB; dec_arith = 1'b1; end
      4'b1011: begin dec_op = OP_CMP; dec_arith = 1'b1; dec_cmp = 1'b1; end
      4'b0001: dec_op = OP_AND;
      4'b0010: dec_op = OP_OR;
      4'b0011: dec_op = OP_XOR;
      default: dec_legal = 1'b0;
    endcase
    if (bus.instruction[15:12] == 4'b0000) begin
      dec_a = 2'b01;
    end else begin
      dec_a = dec_arith ? 2'b10 : 2'b11;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    retired_d = retired_q;
    case (state_q)
      S_FETCH: begin
        if (lat_done && mem_ok) begin
          state_d = S_LOAD;
        end else if (lat_done) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOAD:    state_d = S_DECODE;
      S_DECODE:  state_d = dec_legal ? S_EXECUTE : S_FETCH;
      // Counting on entry to WRITEBACK makes the new total visible alongside instruction_done.
      S_EXECUTE: begin
        state_d   = S_WRITEBACK;
        retired_d = retired_q + 1'b1;
      end
      S_WRITEBACK: state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  always_comb begin
    bus.alu_a_select                 = 2'b00;
    bus.alu_b_select                 = 1'b0;
    bus.alu_operation                = OP_ADD;
    bus.program_counter_write_enable = 1'b0;
    bus.instruction_write_enable     = 1'b0;
    bus.status_write_enable          = 1'b0;
    bus.register_write_enable        = 1'b0;
    bus.instruction_done             = 1'b0;
    bus.illegal_instruction          = 1'b0;
    case (state_q)
      S_LOAD: begin
        bus.instruction_write_enable     = 1'b1;
        bus.program_counter_write_enable = 1'b1;
        bus.alu_b_select                 = 1'b1;
      end
      S_DECODE: bus.illegal_instruction = ~dec_legal;
      S_EXECUTE: begin
        bus.alu_a_select        = dec_a;
        bus.alu_operation       = dec_op;
        bus.status_write_enable = dec_arith;
      end
      S_WRITEBACK: begin
        bus.alu_a_select          = dec_a;
        bus.alu_operation         = dec_op;
        bus.register_write_enable = ~dec_cmp;
        bus.instruction_done      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.retired_count = retired_q;
endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: a 16-bit-count instance plus a 4-bit-count instance for wrap.
module tb_controller;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  controller_if #(.COUNT_WIDTH(16)) bus0 ();
  controller_if #(.COUNT_WIDTH(4))  bus1 ();

  controller #(.MEMORY_LATENCY(1), .COUNT_WIDTH(16)) u0 (.clock(clock), .reset(reset), .bus(bus0));
  controller #(.MEMORY_LATENCY(1), .COUNT_WIDTH(4))  u1 (.clock(clock), .reset(reset), .bus(bus1));

  always #5 clock = ~clock;

  // {ir_we, pc_we, st_we, reg_we, done, illegal, a[1:0], b, op[2:0]}
  function automatic logic [11:0] ov(logic ir, logic pc, logic st, logic rw, logic dn,
                                     logic il, logic [1:0] a, logic b, logic [2:0] op);
    return {ir, pc, st, rw, dn, il, a, b, op};
  endfunction

  function automatic logic [11:0] obs0();
    return {bus0.instruction_write_enable, bus0.program_counter_write_enable,
            bus0.status_write_enable, bus0.register_write_enable,
            bus0.instruction_done, bus0.illegal_instruction,
            bus0.alu_a_select, bus0.alu_b_select, bus0.alu_operation};
  endfunction

  localparam logic [11:0] IDLE = 12'h000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic [15:0] w);
    bus0.instruction = w;
    bus1.instruction = w;
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves at a negedge back in FETCH.
  task automatic run_instr(input string tag, input logic [15:0] w, input logic legal,
                           input logic [1:0] a, input logic [2:0] op,
                           input logic st, input logic rw);
    set_instr(w);
    chk({tag, "_fetch"}, 32'(obs0()), 32'(IDLE));
    @(negedge clock);
    chk({tag, "_load"}, 32'(obs0()), 32'(ov(1, 1, 0, 0, 0, 0, 2'b00, 1, 3'b000)));
    @(negedge clock);
    chk({tag, "_decode"}, 32'(obs0()), 32'(ov(0, 0, 0, 0, 0, !legal, 2'b00, 0, 3'b000)));
    if (!legal) begin
      @(negedge clock);
      chk({tag, "_ill_fetch"}, 32'(obs0()), 32'(IDLE));
      chk({tag, "_ill_count"}, 32'(bus0.retired_count), 32'(exp_cnt));
      return;
    end
    @(negedge clock);
    chk({tag, "_execute"}, 32'(obs0()), 32'(ov(0, 0, st, 0, 0, 0, a, 0, op)));
    @(negedge clock);
    exp_cnt++;
    chk({tag, "_writeback"}, 32'(obs0()), 32'(ov(0, 0, 0, rw, 1, 0, a, 0, op)));
    chk({tag, "_count"}, 32'(bus0.retired_count), 32'(exp_cnt & 32'hFFFF));
    @(negedge clock);
  endtask

  initial begin
    set_instr(16'h0000);
`ifdef CONTROLLER_MEMORY_WAIT_EN
    bus0.memory_ready = 1'b1;
    bus1.memory_ready = 1'b1;
`endif
    @(negedge clock);
    @(negedge clock);
    chk("reset_outs", 32'(obs0()), 32'(IDLE));
    chk("reset_count", 32'(bus0.retired_count), 32'd0);
    reset = 1'b1;

    run_instr("add_reg",  16'h0152, 1'b1, 2'b01, 3'b000, 1'b1, 1'b1);
    run_instr("cmpi",     16'hB3FF, 1'b1, 2'b10, 3'b010, 1'b1, 1'b0);
    run_instr("andi",     16'h1480, 1'b1, 2'b11, 3'b011, 1'b0, 1'b1);
    run_instr("xor_reg",  16'h0234, 1'b1, 2'b01, 3'b101, 1'b0, 1'b1);
    run_instr("subi",     16'h9A7F, 1'b1, 2'b10, 3'b001, 1'b1, 1'b1);
    run_instr("ill_F000", 16'hF000, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
    run_instr("ill_ext0", 16'h0000, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);

    // Reset taken during EXECUTE of an ADD
    set_instr(16'h0152);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    chk("pre_reset_execute", 32'(obs0()), 32'(ov(0, 0, 1, 0, 0, 0, 2'b01, 0, 3'b000)));
    reset = 1'b0;
    #1;
    chk("midreset_outs", 32'(obs0()), 32'(IDLE));
    chk("midreset_count", 32'(bus0.retired_count), 32'd0);
    @(negedge clock);
    chk("midreset_hold", 32'(obs0()), 32'(IDLE));
    reset = 1'b1;
    exp_cnt = 0;
    run_instr("post_reset_add", 16'h0152, 1'b1, 2'b01, 3'b000, 1'b1, 1'b1);

`ifdef CONTROLLER_MEMORY_WAIT_EN
    bus0.memory_ready = 1'b0;
    bus1.memory_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("memwait_hold", 32'(obs0()), 32'(IDLE));
      @(negedge clock);
    end
    bus0.memory_ready = 1'b1;
    bus1.memory_ready = 1'b1;
    run_instr("memwait_add", 16'h0152, 1'b1, 2'b01, 3'b000, 1'b1, 1'b1);
`endif

    // Wrap on the 4-bit instance: 16 retirements return it to zero
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      run_instr("wrap_add", 16'h0152, 1'b1, 2'b01, 3'b000, 1'b1, 1'b1);
      if (i == 14) chk("wrap_count4_15", 32'(bus1.retired_count), 32'd15);
    end
    chk("wrap_count4_0", 32'(bus1.retired_count), 32'd0);
    chk("wrap_count16", 32'(bus0.retired_count), 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
